// File: rtl/rotate_cmd_sequencer_if.sv
// Signal bundle between the rotate command sequencer, its upstream producer,
// the combinational rotate shifter and the downstream result consumer.
interface rotate_cmd_sequencer_if #(
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [2:0]    in_amt;
  logic          in_lr;

  logic [7:0]    sh_a;
  logic [2:0]    sh_amt;
  logic          sh_lr;
  logic [7:0]    sh_y;

  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_y;

  logic [AW:0]   level;

  // Environment side: produces commands, hosts the shifter, consumes results.
  modport master (
    output in_valid, in_a, in_amt, in_lr, sh_y, out_ready,
    input  in_ready, sh_a, sh_amt, sh_lr, out_valid, out_y, level
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_amt, in_lr, sh_y, out_ready,
    output in_ready, sh_a, sh_amt, sh_lr, out_valid, out_y, level
  );
endinterface

// File: rtl/rotate_cmd_sequencer.sv
// Command FIFO plus IDLE/DRIVE/HOLD sequencer that wraps the combinational
// rotate shifter with registered inputs, a registered result and flow control.
module rotate_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rotate_cmd_sequencer_if.slave  bus
);

  localparam int          EW   = 12;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic [7:0]      sh_a_q, sh_a_d;
  logic [2:0]      sh_amt_q, sh_amt_d;
  logic            sh_lr_q, sh_lr_d;
  logic [7:0]      out_y_q, out_y_d;
  logic            out_valid_q, out_valid_d;

  logic            in_ready;
  logic            push;
  logic            pop;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head;

  // Readiness comes from the registered level only, so a full FIFO never
  // accepts a command even in a cycle where the sequencer pops.
  assign in_ready = (level_q != FULL);
  assign push     = bus.in_valid && in_ready;
  assign wr_entry = {bus.in_a, bus.in_amt, bus.in_lr};
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    sh_a_d      = sh_a_q;
    sh_amt_d    = sh_amt_q;
    sh_lr_d     = sh_lr_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop                          = 1'b1;
          {sh_a_d, sh_amt_d, sh_lr_d}  = head;
          state_d                      = DRIVE;
        end
      end
      DRIVE: begin
        // sh_* have been stable for this whole cycle, so sh_y has settled.
        out_y_d     = bus.sh_y;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      sh_a_q      <= '0;
      sh_amt_q    <= '0;
      sh_lr_q     <= 1'b0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      sh_a_q      <= sh_a_d;
      sh_amt_q    <= sh_amt_d;
      sh_lr_q     <= sh_lr_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.sh_a      = sh_a_q;
  assign bus.sh_amt    = sh_amt_q;
  assign bus.sh_lr     = sh_lr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.level     = level_q;

endmodule

// File: doc/rotate_cmd_sequencer.md
Name: rotate_cmd_sequencer

Overview:
Upstream command stage for the 8-bit multifunction rotate shifter. It buffers rotate requests (operand, amount, direction) arriving on a valid/ready interface in a small FIFO. It drives one request at a time onto the shifter's combinational inputs, captures the shifter result into a register, and presents that result downstream on a second valid/ready interface. It gives the purely combinational shifter a registered, flow-controlled wrapper for use in the clocked datapath.

Parameters:
DEPTH, 4, command FIFO depth in entries; must be a power of two and at least 2.
AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream command valid.
in_ready  output  1  FIFO can accept a command; equals (level != DEPTH).
in_a  input  8  operand to rotate.
in_amt  input  3  rotate amount, 0-7.
in_lr  input  1  direction; 1 = rotate right, 0 = rotate left.
sh_a  output  8  registered operand driven to the shifter's a input.
sh_amt  output  3  registered amount driven to the shifter's amt input.
sh_lr  output  1  registered direction driven to the shifter's lr input.
sh_y  input  8  combinational result returned from the shifter's y output.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_y  output  8  registered rotate result.
level  output  AW+1  current FIFO occupancy, 0 to DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers and level go to 0; FSM goes to IDLE; sh_a, sh_amt, sh_lr, out_y and out_valid go to 0.
  - Asserting reset mid-operation discards all queued and in-flight commands. No partial result is emitted after reset releases.
- Push: a push occurs on a clock edge where in_valid && in_ready. The entry {in_a, in_amt, in_lr} is written at the write pointer, and the write pointer wraps modulo DEPTH.
  - in_ready is derived from the registered level only.
  - When full, in_ready is 0 even if a pop happens in the same cycle; no same-cycle push-through.
- Pop: performed only by the FSM in IDLE when level != 0. The read pointer wraps modulo DEPTH.
- Level: a simultaneous push and pop leaves level unchanged. A push alone adds 1; a pop alone subtracts 1.
- FSM states:
  - IDLE: if level != 0, load sh_a/sh_amt/sh_lr from the FIFO head, pop, and go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: the sh_* registers are stable for a full cycle so the shifter settles. At the edge ending DRIVE, out_y <= sh_y, out_valid <= 1, and the FSM goes to HOLD.
  - HOLD: out_valid = 1 and out_y is held stable. When out_ready = 1, the transfer completes at that edge: out_valid <= 0 and the FSM goes to IDLE.
- sh_* outputs retain their last values outside DRIVE and change only on an IDLE pop.
- Latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. out_valid rises at edge N+2. One result completes per 3 cycles at most when out_ready is held high.
- Command order is strict FIFO. Each accepted command produces exactly one result.
- While in HOLD, out_valid stays high and out_y stays stable indefinitely if out_ready is low; upstream pushes continue until the FIFO is full.
- in_amt = 0 passes the operand through unchanged in either direction; this behaviour is the shifter's, and this block does no special-casing.
- No arithmetic beyond modulo-DEPTH pointer wrap and level in the range 0 to DEPTH. Level never over- or underflows.

Test Plan:
- Single command: push a=8'hB3, amt=1, lr=1 with out_ready=1, and the bench model of the shifter attached. Required: out_valid rises two edges after the push, out_y=8'hD9, and level returns to 0.
- Back-to-back stream: push {8'hCA,3,R}, {8'h6C,2,L}, {8'h99,4,L}, {8'hF0,0,L} on consecutive cycles with out_ready=1. Required: results 8'h59, 8'hB1, 8'h99, 8'hF0, in order, with no drops or duplicates.
- Backpressure/full: hold out_ready=0 and push 6 commands. Required: exactly DEPTH+1=5 are accepted (one in HOLD plus 4 queued), in_ready=0 with level=4, and out_y is stable. Releasing out_ready drains all 5 in order.
- Pointer wrap: push and drain 10 mixed commands with random out_ready. Required: every result matches the reference rotate, and in_ready/level stay consistent across pointer wrap.
- Reset mid-operation: with 3 commands queued and the FSM in HOLD, pulse rst_n low asynchronously (not clock-aligned). Required: out_valid, level and the sh_* outputs go to 0 immediately, and no results appear after release until new pushes arrive.
